// File: rtl/mem_stage_lsu_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_pkg
//   Shared definitions for the memory-stage load/store unit: funct3 encodings
//   for loads/stores and the bus-transaction FSM state encoding.
// ---------------------------------------------------------------------------
package mem_stage_lsu_pkg;

  // funct3 load/store widths (stores only use B/H/W)
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage : mem_stage_lsu_pkg

// File: rtl/mem_stage_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_if
//   Request/acknowledge data bus between the LSU (master) and memory (slave).
//   dbus_req    master->slave  request, held until ack or abort
//   dbus_we     master->slave  1 = write
//   dbus_addr   master->slave  word-aligned byte address
//   dbus_be     master->slave  byte enables
//   dbus_wdata  master->slave  lane-replicated store data
//   dbus_ack    slave->master  transfer complete, rdata/err valid
//   dbus_rdata  slave->master  read data
//   dbus_err    slave->master  error, qualified by dbus_ack
// ---------------------------------------------------------------------------
interface mem_stage_lsu_if;

  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        dbus_err;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata, dbus_err
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata, dbus_err
  );

endinterface : mem_stage_lsu_if

// File: rtl/lsu_store_align.sv
// ---------------------------------------------------------------------------
// lsu_store_align
//   Combinational lane alignment for the LSU. From the access width and the
//   low address bits it produces store byte enables, lane-replicated store
//   data and a misalignment flag (valid for loads and stores alike).
//   funct3_i    in  3   access width (undefined encodings behave as W)
//   addr_lo_i   in  2   byte address bits [1:0]
//   data_i      in  32  LSB-justified store data
//   be_o        out 4   byte enables for a store
//   wdata_o     out 32  replicated store data
//   misalign_o  out 1   H/HU on odd address, W on non-word address
// ---------------------------------------------------------------------------
module lsu_store_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    be_o       = 4'b1111;
    wdata_o    = data_i;
    misalign_o = 1'b0;
    case (funct3_i)
      LS_B, LS_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{data_i[7:0]}};
      end
      LS_H, LS_HU: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{data_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      // LS_W and the undefined encodings 011/110/111 are full-word accesses
      default: misalign_o = (addr_lo_i != 2'b00);
    endcase
  end

endmodule : lsu_store_align

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//   Memory-stage load/store unit sitting just before the MEM/WB register.
//   Converts the M-stage access into one req/ack bus transaction, stalls the
//   pipeline while it is in flight and returns the raw 32-bit word; sign/zero
//   extension happens later in W.
//   Parameters: TIMEOUT - BUSY cycles without ack before abort (>= 2)
//   clk, n_rst        clock, asynchronous active-low reset
//   MemReadM/WriteM   load / store in M (both high = store)
//   funct3M           access width
//   ALUResultM        byte address
//   WriteDataM        store data, LSB-justified
//   StallM            hold all pipeline registers up to and including M/W
//   ReadData          raw loaded word to the M/W register
//   MisalignM         1-cycle pulse, misaligned access (no bus cycle)
//   BusErrM           1-cycle pulse, bus error or timeout
//   dbus              data bus, master side
// ---------------------------------------------------------------------------
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [2:0]             funct3M,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  output logic                   StallM,
  output logic [31:0]            ReadData,
  output logic                   MisalignM,
  output logic                   BusErrM,
  mem_stage_lsu_if.master        dbus
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [29:0]       addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              misalign_q;
  logic              buserr_q;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_misalign;
  logic              access;
  logic              start;

  lsu_store_align u_align (
    .funct3_i   (funct3M),
    .addr_lo_i  (ALUResultM[1:0]),
    .data_i     (WriteDataM),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .misalign_o (al_misalign)
  );

  assign access = MemReadM | MemWriteM;
  assign start  = (state_q == IDLE) && access && !al_misalign;

  // The IDLE term is combinational on M-stage inputs, so it is gated with
  // n_rst to keep StallM low for the whole time reset is asserted.
  assign StallM    = (start & n_rst) | (state_q == BUSY);
  assign ReadData  = rdata_q;
  assign MisalignM = misalign_q;
  assign BusErrM   = buserr_q;

  // Request is decoded straight from the state flop, so an async reset
  // removes it immediately.
  assign dbus.dbus_req   = (state_q == BUSY);
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = {addr_q, 2'b00};
  assign dbus.dbus_be    = be_q;
  assign dbus.dbus_wdata = wdata_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every flop samples the
      // pre-edge value of the others, independent of statement order.
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (access && al_misalign) begin
            misalign_q <= 1'b1;
            rdata_q    <= '0;
          end else if (access) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            addr_q  <= ALUResultM[31:2];
            we_q    <= MemWriteM;
            // loads read the whole word; lane selection is done in W
            be_q    <= MemWriteM ? al_be : 4'b1111;
            wdata_q <= MemWriteM ? al_wdata : '0;
          end
        end
        BUSY: begin
          if (dbus.dbus_ack) begin
            state_q <= DONE;
            if (dbus.dbus_err) begin
              rdata_q  <= '0;
              buserr_q <= 1'b1;
            end else if (!we_q) begin
              rdata_q <= dbus.dbus_rdata;
            end
          end else if (cnt_q == CNT_LAST) begin
            // TIMEOUT cycles of req without ack: abort the transfer
            state_q  <= DONE;
            rdata_q  <= '0;
            buserr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : mem_stage_lsu

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
//   Directed bench for mem_stage_lsu with hand-computed expectations.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadData;
  logic        MisalignM;
  logic        BusErrM;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage_lsu_if dbus_if ();

  mem_stage_lsu #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .ReadData   (ReadData),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .dbus       (dbus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait word load started from IDLE; returns to IDLE with no access.
  task automatic do_load(input logic [31:0] addr, input logic [31:0] rdata);
    MemReadM   = 1'b1;
    MemWriteM  = 1'b0;
    funct3M    = 3'b010;
    ALUResultM = addr;
    tick();
    chk("ld_req", dbus_if.dbus_req, 1);
    dbus_if.dbus_ack   = 1'b1;
    dbus_if.dbus_rdata = rdata;
    tick();
    dbus_if.dbus_ack   = 1'b0;
    dbus_if.dbus_rdata = '0;
    chk("ld_rdata", ReadData, rdata);
    chk("ld_buserr", BusErrM, 0);
    MemReadM = 1'b0;
    tick();
  endtask

  initial begin
    n_rst              = 1'b0;
    MemReadM           = 1'b0;
    MemWriteM          = 1'b0;
    funct3M            = 3'b000;
    ALUResultM         = '0;
    WriteDataM         = '0;
    dbus_if.dbus_ack   = 1'b0;
    dbus_if.dbus_rdata = '0;
    dbus_if.dbus_err   = 1'b0;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dbus_if.dbus_req, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_rdata", ReadData, 0);
    chk("rst_misalign", MisalignM, 0);
    chk("rst_buserr", BusErrM, 0);
    n_rst = 1'b1;
    tick();

    // ---- 1: lw 0x1000_0008, zero-wait ack
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h1000_0008;
    #1;
    chk("t1_stall_idle", StallM, 1);
    chk("t1_req_idle", dbus_if.dbus_req, 0);
    tick();
    chk("t1_req", dbus_if.dbus_req, 1);
    chk("t1_addr", dbus_if.dbus_addr, 32'h1000_0008);
    chk("t1_be", dbus_if.dbus_be, 4'b1111);
    chk("t1_we", dbus_if.dbus_we, 0);
    chk("t1_stall_busy", StallM, 1);
    dbus_if.dbus_ack   = 1'b1;
    dbus_if.dbus_rdata = 32'hDEAD_BEEF;
    tick();
    dbus_if.dbus_ack   = 1'b0;
    dbus_if.dbus_rdata = '0;
    chk("t1_stall_done", StallM, 0);
    chk("t1_rdata", ReadData, 32'hDEAD_BEEF);
    chk("t1_req_done", dbus_if.dbus_req, 0);
    tick();
    MemReadM = 1'b0;
    #1;
    chk("t1_stall_after", StallM, 0);
    chk("t1_rdata_hold", ReadData, 32'hDEAD_BEEF);

    // ---- 2: sb 0x1000_0003, data 0xA5
    MemWriteM  = 1'b1;
    funct3M    = 3'b000;
    ALUResultM = 32'h1000_0003;
    WriteDataM = 32'h0000_00A5;
    #1;
    chk("t2_stall_idle", StallM, 1);
    tick();
    chk("t2_req", dbus_if.dbus_req, 1);
    chk("t2_we", dbus_if.dbus_we, 1);
    chk("t2_be", dbus_if.dbus_be, 4'b1000);
    chk("t2_wdata", dbus_if.dbus_wdata, 32'hA5A5_A5A5);
    chk("t2_addr", dbus_if.dbus_addr, 32'h1000_0000);
    dbus_if.dbus_ack   = 1'b1;
    dbus_if.dbus_rdata = 32'h1234_5678;
    tick();
    dbus_if.dbus_ack   = 1'b0;
    chk("t2_req_done", dbus_if.dbus_req, 0);
    chk("t2_stall_done", StallM, 0);
    chk("t2_rdata_kept", ReadData, 32'hDEAD_BEEF);
    tick();

    // sh 0x1000_0002 with read and write both high: a store
    MemReadM   = 1'b1;
    funct3M    = 3'b001;
    ALUResultM = 32'h1000_0002;
    WriteDataM = 32'h1234_BEEF;
    tick();
    chk("t2h_we", dbus_if.dbus_we, 1);
    chk("t2h_be", dbus_if.dbus_be, 4'b1100);
    chk("t2h_wdata", dbus_if.dbus_wdata, 32'hBEEF_BEEF);
    dbus_if.dbus_ack   = 1'b1;
    dbus_if.dbus_rdata = 32'h5555_5555;
    tick();
    dbus_if.dbus_ack   = 1'b0;
    dbus_if.dbus_rdata = '0;
    chk("t2h_rdata_kept", ReadData, 32'hDEAD_BEEF);
    tick();

    // store with undefined funct3 011: full word
    MemReadM   = 1'b0;
    funct3M    = 3'b011;
    ALUResultM = 32'h5000_0004;
    WriteDataM = 32'h0102_0304;
    tick();
    chk("t2u_be", dbus_if.dbus_be, 4'b1111);
    chk("t2u_wdata", dbus_if.dbus_wdata, 32'h0102_0304);
    chk("t2u_addr", dbus_if.dbus_addr, 32'h5000_0004);
    dbus_if.dbus_ack = 1'b1;
    tick();
    dbus_if.dbus_ack = 1'b0;
    tick();

    // ---- 3: sh 0x1000_0001, misaligned
    funct3M    = 3'b001;
    ALUResultM = 32'h1000_0001;
    WriteDataM = 32'h0000_FFFF;
    #1;
    chk("t3_stall", StallM, 0);
    chk("t3_req_idle", dbus_if.dbus_req, 0);
    tick();
    chk("t3_misalign", MisalignM, 1);
    chk("t3_rdata", ReadData, 0);
    chk("t3_req", dbus_if.dbus_req, 0);
    MemWriteM = 1'b0;
    tick();
    chk("t3_misalign_end", MisalignM, 0);
    chk("t3_req_end", dbus_if.dbus_req, 0);

    // ---- 4: lw 0x2000_0010, ack after 5 wait cycles
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h2000_0010;
    #1;
    chk("t4_stall_idle", StallM, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_req_wait", dbus_if.dbus_req, 1);
      chk("t4_addr_wait", dbus_if.dbus_addr, 32'h2000_0010);
      chk("t4_stall_wait", StallM, 1);
      chk("t4_rdata_wait", ReadData, 0);
      tick();
    end
    chk("t4_req_last", dbus_if.dbus_req, 1);
    chk("t4_addr_last", dbus_if.dbus_addr, 32'h2000_0010);
    dbus_if.dbus_ack   = 1'b1;
    dbus_if.dbus_rdata = 32'hCAFE_F00D;
    tick();
    // ack left high with new data in DONE and IDLE must be ignored
    dbus_if.dbus_rdata = 32'h1111_1111;
    MemReadM           = 1'b0;
    chk("t4_rdata", ReadData, 32'hCAFE_F00D);
    chk("t4_stall_done", StallM, 0);
    chk("t4_req_done", dbus_if.dbus_req, 0);
    tick();
    chk("t4_rdata_ign", ReadData, 32'hCAFE_F00D);
    chk("t4_req_ign", dbus_if.dbus_req, 0);
    chk("t4_stall_ign", StallM, 0);
    dbus_if.dbus_ack   = 1'b0;
    dbus_if.dbus_rdata = '0;

    // ---- 5: lw 0x3000_0000, no ack -> timeout after 16 BUSY cycles
    MemReadM   = 1'b1;
    ALUResultM = 32'h3000_0000;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("t5_req", dbus_if.dbus_req, 1);
      chk("t5_stall", StallM, 1);
      tick();
    end
    chk("t5_req_drop", dbus_if.dbus_req, 0);
    chk("t5_buserr", BusErrM, 1);
    chk("t5_rdata", ReadData, 0);
    chk("t5_stall_done", StallM, 0);
    MemReadM = 1'b0;
    tick();
    chk("t5_buserr_end", BusErrM, 0);
    chk("t5_req_end", dbus_if.dbus_req, 0);

    // ---- bus error with ack
    do_load(32'h3000_0004, 32'h0BAD_F00D);
    MemReadM   = 1'b1;
    ALUResultM = 32'h3000_0008;
    tick();
    dbus_if.dbus_ack   = 1'b1;
    dbus_if.dbus_err   = 1'b1;
    dbus_if.dbus_rdata = 32'hFFFF_FFFF;
    tick();
    dbus_if.dbus_ack   = 1'b0;
    dbus_if.dbus_err   = 1'b0;
    dbus_if.dbus_rdata = '0;
    chk("err_rdata", ReadData, 0);
    chk("err_buserr", BusErrM, 1);
    chk("err_stall", StallM, 0);
    MemReadM = 1'b0;
    tick();
    chk("err_buserr_end", BusErrM, 0);

    // ---- 6: reset mid-BUSY
    do_load(32'h4000_0000, 32'h1357_9BDF);
    MemReadM   = 1'b1;
    ALUResultM = 32'h4000_0004;
    tick();
    chk("t6_req_before", dbus_if.dbus_req, 1);
    n_rst = 1'b0;
    #1;
    chk("t6_req_rst", dbus_if.dbus_req, 0);
    chk("t6_stall_rst", StallM, 0);
    chk("t6_rdata_rst", ReadData, 0);
    tick();
    n_rst      = 1'b1;
    funct3M    = 3'b100;
    ALUResultM = 32'h4000_0007;
    #1;
    chk("t6_stall_new", StallM, 1);
    tick();
    chk("t6_req_new", dbus_if.dbus_req, 1);
    chk("t6_be_new", dbus_if.dbus_be, 4'b1111);
    chk("t6_addr_new", dbus_if.dbus_addr, 32'h4000_0004);
    chk("t6_we_new", dbus_if.dbus_we, 0);
    dbus_if.dbus_ack   = 1'b1;
    dbus_if.dbus_rdata = 32'h2468_ACE0;
    tick();
    dbus_if.dbus_ack   = 1'b0;
    dbus_if.dbus_rdata = '0;
    chk("t6_rdata_new", ReadData, 32'h2468_ACE0);
    chk("t6_stall_done", StallM, 0);
    MemReadM = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mem_stage_lsu
